// File: rtl/ps2_command_out.sv
// ps2_command_out: PS/2 host-to-device transmitter; inhibits the device, sends start/8 data/odd parity/stop
// on device clock falling edges, then waits for the device acknowledge.
module ps2_command_out #(
    parameter int CLK_HOLD_CYCLES      = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);
    localparam int MAX_A = CLK_HOLD_CYCLES > START_TIMEOUT_CYCLES ? CLK_HOLD_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_C = MAX_A > XFER_TIMEOUT_CYCLES ? MAX_A : XFER_TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_C + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLK_LOW, S_RTS, S_WAIT_DEV_CLK, S_TX,
        S_WAIT_ACK, S_WAIT_RELEASE, S_DONE, S_ERROR
    } state_t;

    state_t        state, next;
    logic [CW-1:0] cnt, xcnt;
    logic [9:0]    frame;
    logic [3:0]    bit_count;
    logic          clk_low_d, data_low_d, busy_d, sent_d, err_d, xfer_to, start;

    // The registered pulses block a new start so a held request waits out the pulse cycle.
    assign start   = send_command && !command_was_sent && !error_communication_timed_out;
    assign xfer_to = xcnt == CW'(XFER_TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:         next = start ? S_CLK_LOW : S_IDLE;
            S_CLK_LOW:      next = cnt == CW'(CLK_HOLD_CYCLES - 1) ? S_RTS : S_CLK_LOW;
            S_RTS:          next = S_WAIT_DEV_CLK;
            S_WAIT_DEV_CLK: next = ps2_clk_negedge ? S_TX :
                                   cnt == CW'(START_TIMEOUT_CYCLES - 1) ? S_ERROR : S_WAIT_DEV_CLK;
            S_TX:           next = xfer_to ? S_ERROR :
                                   (ps2_clk_negedge && bit_count == 4'd9) ? S_WAIT_ACK : S_TX;
            S_WAIT_ACK:     next = xfer_to ? S_ERROR :
                                   (ps2_clk_negedge && !ps2_data) ? S_WAIT_RELEASE : S_WAIT_ACK;
            S_WAIT_RELEASE: next = xfer_to ? S_ERROR :
                                   (ps2_clk_posedge && ps2_data) ? S_DONE : S_WAIT_RELEASE;
            S_DONE:         next = S_IDLE;
            S_ERROR:        next = S_IDLE;
            default:        next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the start bit is held from RTS until the first data bit.
    always_comb begin
        clk_low_d  = next inside {S_CLK_LOW, S_RTS};
        data_low_d = (state == S_TX && next != S_ERROR) ?
                     (ps2_clk_negedge ? ~frame[0] : ps2_data_drive_low) :
                     (next inside {S_RTS, S_WAIT_DEV_CLK, S_TX});
        busy_d     = next != S_IDLE;
        sent_d     = state == S_DONE;
        err_d      = state == S_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_drive_low             <= 1'b0;
            ps2_data_drive_low            <= 1'b0;
            busy                          <= 1'b0;
            command_was_sent              <= 1'b0;
            error_communication_timed_out <= 1'b0;
            cnt                           <= '0;
            xcnt                          <= '0;
            frame                         <= '0;
            bit_count                     <= '0;
        end else begin
            ps2_clk_drive_low             <= clk_low_d;
            ps2_data_drive_low            <= data_low_d;
            busy                          <= busy_d;
            command_was_sent              <= sent_d;
            error_communication_timed_out <= err_d;
            cnt                           <= (next != state) ? '0 : cnt + CW'(1);
            xcnt                          <= (state inside {S_TX, S_WAIT_ACK, S_WAIT_RELEASE}) ? xcnt + CW'(1) : '0;
            if (state == S_IDLE && start)
                frame <= {1'b1, ~^the_command, the_command};
            else if (state == S_TX && ps2_clk_negedge)
                frame <= {1'b0, frame[9:1]};
            bit_count <= (state != S_TX) ? 4'd0 : ps2_clk_negedge ? bit_count + 4'd1 : bit_count;
        end
    end
endmodule

// File: tb/tb_ps2_command_out.sv
// tb_ps2_command_out: randomized PS/2 device model driving the transmitter, frames checked against
// a reference built from the byte and an odd-parity count.
module tb_ps2_command_out;
    localparam int HOLD = 8;
    localparam int STO  = 50;
    localparam int XTO  = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] the_command = '0;
    logic       send_command = 1'b0;
    logic       pe = 1'b0, ne = 1'b0, dev_low = 1'b0;
    logic       ps2_data;
    logic       ps2_clk_drive_low, ps2_data_drive_low, busy, command_was_sent, error_communication_timed_out;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, sent_n = 0, err_n = 0;

    assign ps2_data = ~(ps2_data_drive_low | dev_low);

    ps2_command_out #(
        .CLK_HOLD_CYCLES(HOLD), .START_TIMEOUT_CYCLES(STO), .XFER_TIMEOUT_CYCLES(XTO)
    ) dut (
        .clk(clk), .reset(reset), .the_command(the_command), .send_command(send_command),
        .ps2_clk_posedge(pe), .ps2_clk_negedge(ne), .ps2_data(ps2_data),
        .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
        .busy(busy), .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (command_was_sent) sent_n <= sent_n + 1;
        if (error_communication_timed_out) err_n <= err_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_neg();
        ne = 1'b1;
        @(negedge clk);
        ne = 1'b0;
    endtask

    task automatic pulse_pos();
        pe = 1'b1;
        @(negedge clk);
        pe = 1'b0;
    endtask

    // Tracks the inhibit/RTS waveform; stray edge strobes are injected while the clock is held low.
    task automatic watch(input bit drop, output int rc, output int rd, output int rl);
        rc = 0; rd = 0; rl = 0;
        for (int i = 1; i <= HOLD + 20 && rl == 0; i++) begin
            @(negedge clk);
            if (drop) send_command = 1'b0;
            ne = (rc != 0 && i == rc + 2);
            pe = (rc != 0 && i == rc + 4);
            if (ps2_clk_drive_low && rc == 0) rc = i;
            if (ps2_data_drive_low && rd == 0) rd = i;
            if (!ps2_clk_drive_low && rc != 0) rl = i;
        end
        ne = 1'b0; pe = 1'b0;
    endtask

    task automatic check_start(input int rc, input int rd, input int rl, input int rc_exp);
        chk("clk_rise", rc, rc_exp);
        chk("rts_offset", rd - rc, HOLD);
        chk("clk_release_offset", rl - rc, HOLD + 1);
    endtask

    task automatic launch(input logic [7:0] b);
        int rc, rd, rl;
        the_command = b;
        send_command = 1'b1;
        watch(1'b1, rc, rd, rl);
        check_start(rc, rd, rl, 1);
    endtask

    task automatic device(input int nclk, input bit ack, input int gap, output logic [10:0] fr, output int t0);
        fr = '0;
        t0 = cyc;
        for (int i = 0; i < nclk; i++) begin
            pulse_neg();
            tick(gap);
            fr[i] = ps2_data;
            pulse_pos();
            tick(gap);
        end
        if (ack) begin
            dev_low = 1'b1;
            tick(gap);
            pulse_neg();
            tick(gap);
            dev_low = 1'b0;
            tick(1);
            pulse_pos();
        end
    endtask

    task automatic wait_pulse(input bit err, input string tag);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(err ? error_communication_timed_out : command_was_sent) && i < 1000);
        chk({tag, "_seen"}, int'(err ? error_communication_timed_out : command_was_sent), 1);
    endtask

    task automatic normal(input logic [7:0] b);
        int s0 = sent_n, e0 = err_n, t0;
        logic [10:0] fr;
        launch(b);
        device(11, 1'b1, $urandom_range(1, 4), fr, t0);
        wait_pulse(1'b0, "sent");
        chk($sformatf("frame_%02h", b), int'(fr), int'(ref_frame(b)));
        chk("busy_at_sent", int'(busy), 0);
        tick(2);
        chk("sent_once", sent_n - s0, 1);
        chk("no_err", err_n - e0, 0);
        chk("lines_released", int'({ps2_clk_drive_low, ps2_data_drive_low}), 0);
    endtask

    initial begin
        logic [7:0] dir [4] = '{8'hF4, 8'hFF, 8'h00, 8'hED};
        logic [7:0] a, b;
        logic [10:0] fr;
        int r, d, t0, s0, e0, rc, rd, rl;

        tick(3);
        chk("rst_outputs", int'({ps2_clk_drive_low, ps2_data_drive_low, busy, command_was_sent,
                                 error_communication_timed_out}), 0);
        reset = 1'b0;
        tick(2);

        foreach (dir[i]) normal(dir[i]);
        repeat (6) normal(8'($urandom));

        s0 = sent_n; e0 = err_n;
        launch(8'h3C);
        r = cyc;
        wait_pulse(1'b1, "start_err");
        d = cyc - r;
        chk($sformatf("start_timeout_cycles_%0d", d), int'(d >= STO + 1 && d <= STO + 2), 1);
        chk("start_err_lines", int'({ps2_clk_drive_low, ps2_data_drive_low, busy}), 0);
        tick(2);
        chk("start_err_once", err_n - e0, 1);
        chk("start_err_no_sent", sent_n - s0, 0);

        s0 = sent_n; e0 = err_n;
        a = 8'($urandom);
        launch(a);
        device(11, 1'b0, $urandom_range(1, 4), fr, t0);
        chk("noack_frame", int'(fr), int'(ref_frame(a)));
        wait_pulse(1'b1, "xfer_err");
        d = cyc - t0;
        chk($sformatf("xfer_timeout_cycles_%0d", d), int'(d >= XTO + 1 && d <= XTO + 3), 1);
        chk("xfer_err_lines", int'({ps2_clk_drive_low, ps2_data_drive_low, busy}), 0);
        tick(2);
        chk("xfer_err_once", err_n - e0, 1);
        chk("xfer_err_no_sent", sent_n - s0, 0);
        normal(8'hAA);

        s0 = sent_n; e0 = err_n;
        launch(8'($urandom));
        device(5, 1'b0, $urandom_range(1, 4), fr, t0);
        chk("busy_mid_tx", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_tx", int'({ps2_clk_drive_low, ps2_data_drive_low, busy, command_was_sent,
                                  error_communication_timed_out}), 0);
        tick(3);
        chk("reset_no_pulses", (sent_n - s0) + (err_n - e0), 0);
        normal(8'h55);

        a = 8'($urandom);
        b = ~a;
        the_command = a;
        send_command = 1'b1;
        watch(1'b0, rc, rd, rl);
        check_start(rc, rd, rl, 1);
        the_command = b;
        device(11, 1'b1, $urandom_range(1, 4), fr, t0);
        wait_pulse(1'b0, "held1_sent");
        chk("held1_frame", int'(fr), int'(ref_frame(a)));
        watch(1'b0, rc, rd, rl);
        check_start(rc, rd, rl, 2);
        send_command = 1'b0;
        the_command = 8'($urandom);
        device(11, 1'b1, $urandom_range(1, 4), fr, t0);
        wait_pulse(1'b0, "held2_sent");
        chk("held2_frame", int'(fr), int'(ref_frame(b)));
        tick(4);
        chk("idle_after_held", int'({busy, ps2_clk_drive_low, ps2_data_drive_low}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
